// File: rtl/dvi_tx_timing_gen.sv
// DVI transmit timing generator: h/v phase FSMs, a pixel request stage and an output stage aligned for the TMDS encoder.
// Define DVI_TX_PATTERN_EN to replace rgb_in with a built-in 8-bar colour pattern.
module dvi_tx_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        pixel_clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [23:0] rgb_in,
    output logic        pixel_req,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start,
    output logic        den,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] pixel_data
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] H_FP_END   = 12'(H_ACTIVE + H_FP - 1);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE - 1);
    localparam logic [11:0] V_FP_END   = 12'(V_ACTIVE + V_FP - 1);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_total_check
            $error("dvi_tx_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
        end
    endgenerate

    typedef enum logic [1:0] {ST_H_ACTIVE, ST_H_FRONT, ST_H_SYNC, ST_H_BACK} h_state_t;
    typedef enum logic [1:0] {ST_V_ACTIVE, ST_V_FRONT, ST_V_SYNC, ST_V_BACK} v_state_t;

    h_state_t    r_h_state, w_h_state_next;
    v_state_t    r_v_state, w_v_state_next;
    logic [11:0] r_h_cnt, r_v_cnt, w_h_cnt_next, w_v_cnt_next;
    logic        w_h_wrap, w_active;

    logic        r_req, r_fs, r_hs1, r_vs1;
    logic [11:0] r_x, r_y;
    logic        r_den, r_hsync, r_vsync;
    logic [23:0] r_pixel_data, w_pixel_src;

    // Disabling parks the counters at the top of a frame so re-enabling starts cleanly.
    always_ff @(posedge pixel_clock) begin
        if (reset || !enable) begin
            r_h_cnt   <= 12'd0;
            r_v_cnt   <= 12'd0;
            r_h_state <= ST_H_ACTIVE;
            r_v_state <= ST_V_ACTIVE;
        end else begin
            r_h_cnt   <= w_h_cnt_next;
            r_v_cnt   <= w_v_cnt_next;
            r_h_state <= w_h_state_next;
            r_v_state <= w_v_state_next;
        end
    end

    always_comb begin
        w_h_wrap       = (r_h_cnt == H_LAST);
        w_h_cnt_next   = w_h_wrap ? 12'd0 : r_h_cnt + 12'd1;
        w_v_cnt_next   = r_v_cnt;
        w_h_state_next = r_h_state;
        w_v_state_next = r_v_state;

        case (r_h_state)
            ST_H_ACTIVE: if (r_h_cnt == H_ACT_END)  w_h_state_next = ST_H_FRONT;
            ST_H_FRONT:  if (r_h_cnt == H_FP_END)   w_h_state_next = ST_H_SYNC;
            ST_H_SYNC:   if (r_h_cnt == H_SYNC_END) w_h_state_next = ST_H_BACK;
            default:     if (w_h_wrap)              w_h_state_next = ST_H_ACTIVE;
        endcase

        // The vertical side only moves on the line wrap, keeping vsync edges on line starts.
        if (w_h_wrap) begin
            w_v_cnt_next = (r_v_cnt == V_LAST) ? 12'd0 : r_v_cnt + 12'd1;
            case (r_v_state)
                ST_V_ACTIVE: if (r_v_cnt == V_ACT_END)  w_v_state_next = ST_V_FRONT;
                ST_V_FRONT:  if (r_v_cnt == V_FP_END)   w_v_state_next = ST_V_SYNC;
                ST_V_SYNC:   if (r_v_cnt == V_SYNC_END) w_v_state_next = ST_V_BACK;
                default:     if (r_v_cnt == V_LAST)     w_v_state_next = ST_V_ACTIVE;
            endcase
        end

        w_active = (r_h_state == ST_H_ACTIVE) && (r_v_state == ST_V_ACTIVE);
    end

    always_ff @(posedge pixel_clock) begin
        if (reset || !enable) begin
            r_req <= 1'b0;
            r_x   <= 12'd0;
            r_y   <= 12'd0;
            r_fs  <= 1'b0;
            r_hs1 <= 1'b0;
            r_vs1 <= 1'b0;
        end else begin
            r_req <= w_active;
            if (w_active) begin
                r_x <= r_h_cnt;
                r_y <= r_v_cnt;
            end
            r_fs  <= w_active && (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0);
            r_hs1 <= (r_h_state == ST_H_SYNC);
            r_vs1 <= (r_v_state == ST_V_SYNC);
        end
    end

`ifdef DVI_TX_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [23:0] BAR_COLOURS [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };
    logic w_unused_rgb;
    assign w_unused_rgb = ^rgb_in;

    // Columns past the last full bar fall through to black.
    always_comb begin
        w_pixel_src = 24'h0;
        for (int i = 0; i < 8; i++) begin
            if (int'(r_x) >= i * BAR_W && int'(r_x) < (i + 1) * BAR_W)
                w_pixel_src = BAR_COLOURS[i];
        end
    end
`else
    assign w_pixel_src = rgb_in;
`endif

    always_ff @(posedge pixel_clock) begin
        if (reset) begin
            r_den        <= 1'b0;
            r_hsync      <= ~HS_POL;
            r_vsync      <= ~VS_POL;
            r_pixel_data <= 24'h0;
        end else begin
            r_den        <= r_req;
            r_hsync      <= r_hs1 ? HS_POL : ~HS_POL;
            r_vsync      <= r_vs1 ? VS_POL : ~VS_POL;
            r_pixel_data <= r_req ? w_pixel_src : 24'h0;
        end
    end

    assign pixel_req   = r_req;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_fs;
    assign den         = r_den;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign pixel_data  = r_pixel_data;

endmodule

// File: tb/tb_dvi_tx_timing_gen.sv
// Directed self-checking bench for dvi_tx_timing_gen using a reduced 24x10 timing so whole frames fit in a short run.
module tb_dvi_tx_timing_gen;

    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;

    logic        pixel_clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [23:0] rgb_in;
    logic        pixel_req;
    logic [11:0] x;
    logic [11:0] y;
    logic        frame_start;
    logic        den;
    logic        hsync;
    logic        vsync;
    logic [23:0] pixel_data;

    int checkCount = 0;
    int errorCount = 0;

    // Reference state: counters and the two pipeline stages, derived from counter ranges.
    int          mH, mV;
    logic        mReq, mFs, mInHs, mInVs;
    logic [11:0] mX, mY;
    logic        mDen, mHs, mVs;
    logic [23:0] mPd;

    int cycleIdx, fsCount, firstFs, secondFs, denHigh, hsLow;

    dvi_tx_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .pixel_clock (pixel_clock),
        .reset       (reset),
        .enable      (enable),
        .rgb_in      (rgb_in),
        .pixel_req   (pixel_req),
        .x           (x),
        .y           (y),
        .frame_start (frame_start),
        .den         (den),
        .hsync       (hsync),
        .vsync       (vsync),
        .pixel_data  (pixel_data)
    );

    always #5 pixel_clock = ~pixel_clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Hand table of bar colours for a 16-pixel active line (bars two pixels wide).
    function automatic logic [23:0] barColour(input logic [11:0] col);
        case (col / 12'd2)
            12'd0:   return 24'hFFFFFF;
            12'd1:   return 24'hFFFF00;
            12'd2:   return 24'h00FFFF;
            12'd3:   return 24'h00FF00;
            12'd4:   return 24'hFF00FF;
            12'd5:   return 24'hFF0000;
            12'd6:   return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic stepModel();
        if (reset) begin
            mH = 0; mV = 0;
            mReq = 1'b0; mX = 12'd0; mY = 12'd0; mFs = 1'b0; mInHs = 1'b0; mInVs = 1'b0;
            mDen = 1'b0; mHs = 1'b1; mVs = 1'b1; mPd = 24'h0;
        end else begin
            mDen = mReq;
            mHs  = !mInHs;
            mVs  = !mInVs;
`ifdef DVI_TX_PATTERN_EN
            mPd  = mReq ? barColour(mX) : 24'h0;
`else
            mPd  = mReq ? {mX[7:0], mY[7:0], 8'hA5} : 24'h0;
`endif
            if (!enable) begin
                mH = 0; mV = 0;
                mReq = 1'b0; mX = 12'd0; mY = 12'd0; mFs = 1'b0; mInHs = 1'b0; mInVs = 1'b0;
            end else begin
                mReq = (mH < 16) && (mV < 6);
                if (mReq) begin
                    mX = 12'(mH);
                    mY = 12'(mV);
                end
                mFs   = mReq && (mH == 0) && (mV == 0);
                mInHs = (mH >= 18) && (mH < 21);
                mInVs = (mV >= 7) && (mV < 9);
                mH++;
                if (mH == 24) begin
                    mH = 0;
                    mV++;
                    if (mV == 10) mV = 0;
                end
            end
        end
    endtask

    task automatic applyStimulus(input int cycles, input bit tally);
        for (int i = 0; i < cycles; i++) begin
`ifdef DVI_TX_PATTERN_EN
            rgb_in = 24'($urandom);
`else
            rgb_in = {x[7:0], y[7:0], 8'hA5};
`endif
            @(posedge pixel_clock);
            stepModel();
            @(negedge pixel_clock);
            checkOutput("pixel_req",   {31'd0, pixel_req},   {31'd0, mReq});
            checkOutput("x",           {20'd0, x},           {20'd0, mX});
            checkOutput("y",           {20'd0, y},           {20'd0, mY});
            checkOutput("frame_start", {31'd0, frame_start}, {31'd0, mFs});
            checkOutput("den",         {31'd0, den},         {31'd0, mDen});
            checkOutput("hsync",       {31'd0, hsync},       {31'd0, mHs});
            checkOutput("vsync",       {31'd0, vsync},       {31'd0, mVs});
            checkOutput("pixel_data",  {8'd0, pixel_data},   {8'd0, mPd});
            if (tally) begin
                cycleIdx++;
                if (frame_start) begin
                    fsCount++;
                    if (firstFs < 0) firstFs = cycleIdx;
                    else if (secondFs < 0) secondFs = cycleIdx;
                end
                if (den) denHigh++;
                if (!hsync) hsLow++;
            end
        end
    endtask

    initial begin
        int guard;
        cycleIdx = 0; fsCount = 0; firstFs = -1; secondFs = -1; denHigh = 0; hsLow = 0;
        reset  = 1'b1;
        enable = 1'b0;
        rgb_in = 24'h0;
        @(negedge pixel_clock);
        applyStimulus(3, 1'b0);
        checkOutput("rst_hsync", {31'd0, hsync}, 32'd1);
        checkOutput("rst_den",   {31'd0, den},   32'd0);

        // Free-running from (0,0): 240-cycle frame, 16 active pixels and 3 sync pixels per line.
        reset  = 1'b0;
        enable = 1'b1;
        applyStimulus(300, 1'b1);
        checkOutput("fs_count",  32'(fsCount),            32'd2);
        checkOutput("fs_period", 32'(secondFs - firstFs), 32'd240);
        checkOutput("den_high",  32'(denHigh),            32'd139);
        checkOutput("hs_low",    32'(hsLow),              32'd36);

        // Abort mid-frame at line 2 pixel 5, then restart.
        guard = 0;
        while (!(mH == 5 && mV == 2) && guard < 500) begin
            applyStimulus(1, 1'b0);
            guard++;
        end
        enable = 1'b0;
        applyStimulus(1, 1'b0);
        checkOutput("drop_req", {31'd0, pixel_req}, 32'd0);
        applyStimulus(1, 1'b0);
        checkOutput("drop_den",   {31'd0, den},   32'd0);
        checkOutput("drop_hsync", {31'd0, hsync}, 32'd1);
        checkOutput("drop_vsync", {31'd0, vsync}, 32'd1);
        applyStimulus(2, 1'b0);
        enable = 1'b1;
        applyStimulus(1, 1'b0);
        checkOutput("reen_fs", {31'd0, frame_start}, 32'd1);
        checkOutput("reen_x",  {20'd0, x},           32'd0);
        checkOutput("reen_y",  {20'd0, y},           32'd0);
        applyStimulus(40, 1'b0);

        // Reset while the vsync lines are in flight.
        guard = 0;
        while (!(mH == 3 && mV == 8) && guard < 500) begin
            applyStimulus(1, 1'b0);
            guard++;
        end
        checkOutput("pre_rst_vsync", {31'd0, vsync}, 32'd0);
        reset = 1'b1;
        applyStimulus(1, 1'b0);
        checkOutput("mid_rst_vsync", {31'd0, vsync},      32'd1);
        checkOutput("mid_rst_hsync", {31'd0, hsync},      32'd1);
        checkOutput("mid_rst_req",   {31'd0, pixel_req},  32'd0);
        checkOutput("mid_rst_pd",    {8'd0, pixel_data},  32'd0);
        reset = 1'b0;
        applyStimulus(1, 1'b0);
        checkOutput("post_rst_fs", {31'd0, frame_start}, 32'd1);
        applyStimulus(60, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/dvi_tx_timing_gen.md
# dvi_tx_timing_gen

Video timing controller that sequences the DVI transmit datapath. It runs horizontal and vertical phase state machines in the pixel clock domain and issues a pixel request with x/y coordinates to the frame source. It samples the returned RGB one cycle later and drives `den`, `hsync`, `vsync` and `pixel_data` into the TMDS encoder/serializer top, with all four signals aligned. An optional built-in colour-bar generator provides bring-up video without a frame source.

## Interface
Parameters:
- `H_ACTIVE`, 640: active pixels per line
- `H_FP`, 16: horizontal front porch, in pixels
- `H_SYNC`, 96: hsync width, in pixels
- `H_BP`, 48: horizontal back porch, in pixels
- `V_ACTIVE`, 480: active lines per frame
- `V_FP`, 10: vertical front porch, in lines
- `V_SYNC`, 2: vsync width, in lines
- `V_BP`, 33: vertical back porch, in lines
- `HS_POL`, 0: hsync asserted level (0 = active-low)
- `VS_POL`, 0: vsync asserted level (0 = active-low)

Ports:
- `pixel_clock` in 1: sole clock; all logic is on its rising edge
- `reset` in 1: synchronous, active-high
- `enable` in 1: run the timing; low forces idle
- `rgb_in` in 24: pixel from the source, `{R[23:16], G[15:8], B[7:0]}`, valid 1 cycle after `pixel_req`
- `pixel_req` out 1: registered; the source must present the pixel at (`x`,`y`) on the next cycle
- `x` out 12: registered active column, 0..H_ACTIVE-1
- `y` out 12: registered active line, 0..V_ACTIVE-1
- `frame_start` out 1: one-cycle pulse coincident with `pixel_req` at (0,0)
- `den` out 1: to encoder
- `hsync` out 1: to encoder
- `vsync` out 1: to encoder
- `pixel_data` out 24: to encoder

## Operation
- Counters `h_cnt` and `v_cnt` are 12 bits each.
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Both totals must be ≤ 4096. This is checked with an elaboration-time error.
- Horizontal FSM: H_ACTIVE → H_FRONT → H_SYNC → H_BACK → H_ACTIVE.
  - Each phase lasts its parameter length.
  - `h_cnt` wraps from H_TOTAL-1 to 0.
- Vertical FSM: V_ACTIVE → V_FRONT → V_SYNC → V_BACK → V_ACTIVE.
  - It advances only on the `h_cnt` wrap cycle, so vsync edges coincide with line start (h=0).
  - `v_cnt` wraps from V_TOTAL-1 to 0.
- Stage 1 (registered from the counters):
  - `pixel_req` = both FSMs in ACTIVE.
  - `x`/`y` = counters when `pixel_req` is high; they hold their last value otherwise.
  - `frame_start` = `pixel_req` at h=0, v=0.
- Stage 2 (registered from stage 1):
  - `den` = delayed `pixel_req`.
  - `hsync` = HS_POL while in H_SYNC, else ~HS_POL.
  - `vsync` = VS_POL while in V_SYNC, else ~VS_POL.
  - `pixel_data` = `rgb_in` when stage-1 `pixel_req` was high, else 24'h0.
- `enable` low:
  - Next edge: counters go to (0,0), both FSMs go to ACTIVE, and stage-1 outputs go to their reset values.
  - The edge after: stage-2 outputs go to their reset values.
  - Mid-frame deassertion aborts the frame with no completion.
  - Re-assertion starts a fresh frame at (0,0) with `frame_start`.
- `reset` overrides `enable`.
- Reset values: `pixel_req`=0, `x`=0, `y`=0, `frame_start`=0, `den`=0, `hsync`=~HS_POL, `vsync`=~VS_POL, `pixel_data`=0.

## Timing
- Latency: `pixel_req` → `den`/`pixel_data` is 1 cycle. `hsync`/`vsync` are pipeline-aligned with `den`.
- The first `pixel_req` occurs 1 cycle after the first edge with `enable`=1 and `reset`=0.
- With defaults:
  - Line period is 800 cycles; `den` is high for 640 cycles.
  - `hsync` asserts 656 cycles after the `den` rising edge and lasts 96 cycles.
  - `vsync` asserts at the start of line 490 and lasts 2 lines (1600 cycles).
  - Frame period is 420000 cycles.
- Any `rgb_in` value is accepted; no back-pressure exists. The source must meet the 1-cycle response.

## Configuration
- `DVI_TX_PATTERN_EN` defined:
  - `rgb_in` is ignored.
  - Stage 2 drives 8 vertical colour bars, each bar floor(H_ACTIVE/8) pixels wide. Any remainder columns are black.
  - Bar order by column: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - `pixel_req`, `x`, `y` and `frame_start` still operate normally.
- `DVI_TX_PATTERN_EN` undefined: `pixel_data` is sourced from `rgb_in` as described in Operation.

## Test plan
- Defaults, reset released, `enable`=1: count cycles from the `den` rise. Expect:
  - `den` high 640 cycles, then low 160.
  - `hsync` low for cycles 656..751.
  - Frame period 420000, with exactly one `frame_start` per frame.
- `rgb_in` = {x[7:0], y[7:0], 8'hA5}, returned 1 cycle after `pixel_req`: each `pixel_data` sample with `den`=1 matches the (`x`,`y`) issued one cycle earlier. `pixel_data`=0 whenever `den`=0.
- Drop `enable` at line 100, pixel 300: the next edge shows `pixel_req`=0. The edge after shows `den`=0, `hsync`=1 and `vsync`=1. Re-assert `enable`: `frame_start` appears with x=0, y=0.
- Assert `reset` during the vsync pulse (line 491): all outputs take their reset values on the next edge. The timing restarts at (0,0) after release.
- `HS_POL`=1, `VS_POL`=1, H_ACTIVE=1280/H_FP=110/H_SYNC=40/H_BP=220, V_ACTIVE=720/V_FP=5/V_SYNC=5/V_BP=20: expect a 1650-cycle line, a 750-line frame, and `hsync` high for 40 cycles.
- `DVI_TX_PATTERN_EN` defined, defaults: `pixel_data` is FFFFFF for pixels 0..79, FFFF00 at pixel 80, and 000000 at pixel 560..639. `rgb_in` toggling has no effect.
